// File: rtl/reg_read_stage.sv
// Register-read stage: 2-read/1-write register file feeding one registered ALU operand/control slot.
// Optional `REGFILE_BYPASS_EN: a same-cycle write to a read address is returned on that read.
module reg_read_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic [3:0]        alu_ctrl_in,
  input  logic [2:0]        bonus_ctrl_in,
  input  logic              stall,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  output logic              out_valid,
  output logic [DATA_W-1:0] src1,
  output logic [DATA_W-1:0] src2,
  output logic [3:0]        ALU_control,
  output logic [2:0]        bonus_control
);

  localparam int NREG  = 1 << ADDR_W;
  localparam int NRD   = 2;

  logic [DATA_W-1:0] regs_q [NREG];

  // Register 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we && (wa != '0)) begin
      regs_q[wa] <= wd;
    end
  end

  logic [NRD-1:0][ADDR_W-1:0] raddr;
  logic [NRD-1:0][DATA_W-1:0] rdata;

  assign raddr[0] = rs_addr;
  assign raddr[1] = rt_addr;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    always_comb begin
      rdata[p] = regs_q[raddr[p]];
      if (raddr[p] == '0) begin
        rdata[p] = '0;
`ifdef REGFILE_BYPASS_EN
      end else if (we && (wa == raddr[p])) begin
        rdata[p] = wd;
`endif
      end
    end
  end

  logic              vld_q, vld_d;
  logic [DATA_W-1:0] src1_q, src1_d, src2_q, src2_d;
  logic [3:0]        alu_q, alu_d;
  logic [2:0]        bonus_q, bonus_d;

  // A stall freezes everything and drops the request; idle cycles only clear valid.
  always_comb begin
    vld_d   = vld_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    alu_d   = alu_q;
    bonus_d = bonus_q;
    if (!stall) begin
      vld_d = in_valid;
      if (in_valid) begin
        src1_d  = rdata[0];
        src2_d  = rdata[1];
        alu_d   = alu_ctrl_in;
        bonus_d = bonus_ctrl_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= 1'b0;
      src1_q  <= '0;
      src2_q  <= '0;
      alu_q   <= '0;
      bonus_q <= '0;
    end else begin
      vld_q   <= vld_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      alu_q   <= alu_d;
      bonus_q <= bonus_d;
    end
  end

  assign out_valid     = vld_q;
  assign src1          = src1_q;
  assign src2          = src2_q;
  assign ALU_control   = alu_q;
  assign bonus_control = bonus_q;

endmodule

// File: doc/reg_read_stage.md
REG_READ_STAGE -- requirements
Module: reg_read_stage

Interface
REQ-001 The module SHALL expose parameter DATA_W, default 32, operand and register width.
REQ-002 The module SHALL expose parameter ADDR_W, default 5, register address width (2**ADDR_W registers).
REQ-003 The module SHALL have port clk  input  1  rising-edge clock, the single clock of the block.
REQ-004 The module SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The module SHALL have port in_valid  input  1  issue request carrying rs_addr/rt_addr/control.
REQ-006 The module SHALL have port rs_addr  input  ADDR_W  source-1 register index.
REQ-007 The module SHALL have port rt_addr  input  ADDR_W  source-2 register index.
REQ-008 The module SHALL have port alu_ctrl_in  input  4  ALU operation code, passed through.
REQ-009 The module SHALL have port bonus_ctrl_in  input  3  compare-mode code, passed through.
REQ-010 The module SHALL have port stall  input  1  downstream ALU/execute stage not accepting; hold outputs.
REQ-011 The module SHALL have port we  input  1  write-back enable.
REQ-012 The module SHALL have port wa  input  ADDR_W  write-back register index.
REQ-013 The module SHALL have port wd  input  DATA_W  write-back data.
REQ-014 The module SHALL have port out_valid  output  1  registered operands valid for the ALU.
REQ-015 The module SHALL have ports src1 and src2  output  DATA_W each  registered ALU operands.
REQ-016 The module SHALL have ports ALU_control (output, 4) and bonus_control (output, 3)  registered control for the ALU.

Function
REQ-017 Storage SHALL be 2**ADDR_W registers of DATA_W bits; register 0 SHALL always read 0, and writes to it SHALL be ignored.
REQ-018 On a rising clk edge with we=1 and wa!=0, register[wa] SHALL take wd, regardless of stall or in_valid.
REQ-019 Operand read value SHALL be: 0 if the address is 0; otherwise the bypass value per REQ-029/030; otherwise register[addr].
REQ-020 Latency SHALL be exactly one cycle: issue at edge N -> out_valid, src1, src2, controls updated after edge N.
REQ-021 With stall=0 at an edge: out_valid <= in_valid; if in_valid=1, then src1, src2, ALU_control and bonus_control load the read values and the control inputs.
REQ-022 With stall=0 and in_valid=0, out_valid SHALL become 0, and src1/src2/control outputs SHALL hold their previous values.
REQ-023 With stall=1 at an edge: out_valid, src1, src2 and control outputs SHALL all hold; the in_valid request is dropped, and the issuer is responsible for re-presenting it.
REQ-024 Held operands SHALL NOT be refreshed by writes that occur during a stall; forwarding of such writes is the execute stage's concern.
REQ-025 Same-edge writes to registers rs_addr and rt_addr with rs_addr==rt_addr SHALL yield identical src1 and src2.

Reset
REQ-026 While rst_n=0, all registers, src1, src2, ALU_control, bonus_control and out_valid SHALL be 0, asynchronously.
REQ-027 Deassertion of rst_n SHALL take effect at the next rising edge; a write or issue coincident with the reset assertion SHALL be lost.
REQ-028 Reset asserted mid-stall SHALL clear out_valid, with no replay after release.

Configuration
REQ-029 With macro REGFILE_BYPASS_EN defined, a read whose nonzero address equals wa while we=1 in the same cycle SHALL return wd (write-through).
REQ-030 Without REGFILE_BYPASS_EN, that read SHALL return the pre-write register contents; the new value is visible from the next cycle.

Verification
REQ-031 Reset then issue rs=3, rt=4 -> next cycle out_valid=1, src1=0, src2=0.
REQ-032 Write r5=0x0000_00AA; next cycle issue rs=5, rt=0, ctrl=4'b0010 -> src1=0x0000_00AA, src2=0, ALU_control=4'b0010.
REQ-033 Write r0=0xFFFF_FFFF, then issue rs=0 -> src1=0.
REQ-034 Same-cycle we=1, wa=7, wd=0x1234_5678, issue rs=7 -> with REGFILE_BYPASS_EN src1=0x1234_5678; without it src1=the old r7 value.
REQ-035 Issue rs=5, then stall=1 for 3 cycles while writing r5=0x55 -> src1 holds 0x0000_00AA and out_valid stays 1; after stall=0 with in_valid=0, out_valid=0.
REQ-036 Assert rst_n=0 during a stall with out_valid=1 -> out_valid and src1 go to 0 immediately, without waiting for clk.
